cbfp0_min_shift_acc: RTL and testbench



---
 rtl/cbfp0_pkg.sv | 21 ++
 rtl/cbfp0_lane_min.sv | 47 ++++
 rtl/cbfp0_min_shift_acc.sv | 119 +++++++++++
 tb/tb_cbfp0_min_shift_acc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cbfp0_pkg.sv
// Shared constants and types for the CBFP stage-0 minimum-shift accumulator.
// Parameter defaults of the modules below are taken from here.
package cbfp0_pkg;

    localparam int LANES     = 4;
    localparam int CNT_W     = 5;
    localparam int WIN_LEN   = 32;
    localparam int GRP_LEN   = 8;
    localparam int SHIFT_MAX = 20;

    // Groups per window and the counter widths that follow from them.
    localparam int N_GRP = WIN_LEN / GRP_LEN;
    localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int CYC_W = $clog2(GRP_LEN) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/cbfp0_lane_min.sv
// First pipeline stage: saturate every lane count to SHIFT_MAX, take the
// minimum across lanes and register it together with the window enable.
module cbfp0_lane_min #(
    parameter int LANES     = cbfp0_pkg::LANES,
    parameter int CNT_W     = cbfp0_pkg::CNT_W,
    parameter int SHIFT_MAX = cbfp0_pkg::SHIFT_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic [LANES*CNT_W-1:0] cnt_in,
    output logic                   en_out,
    output logic [CNT_W-1:0]       lane_min
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(SHIFT_MAX);

    logic [CNT_W-1:0] lane_c;
    logic [CNT_W-1:0] min_c;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        lane_c = '0;
        min_c  = SAT;
        for (int i = 0; i < LANES; i++) begin
            lane_c = cnt_in[i*CNT_W +: CNT_W];
            if (lane_c > SAT) begin
                lane_c = SAT;
            end
            if (lane_c < min_c) begin
                min_c = lane_c;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out   <= 1'b0;
            lane_min <= SAT;
        end else begin
            en_out   <= en_in;
            lane_min <= min_c;
        end
    end

endmodule

// File: rtl/cbfp0_min_shift_acc.sv
// Reduces per-lane shift counts to one block exponent per group of GRP_LEN
// enabled cycles; flags windows that drop before WIN_LEN cycles.
module cbfp0_min_shift_acc #(
    parameter int   LANES     = cbfp0_pkg::LANES,
    parameter int   CNT_W     = cbfp0_pkg::CNT_W,
    parameter int   WIN_LEN   = cbfp0_pkg::WIN_LEN,
    parameter int   GRP_LEN   = cbfp0_pkg::GRP_LEN,
    parameter int   SHIFT_MAX = cbfp0_pkg::SHIFT_MAX,
    localparam int  IDX_W     = $clog2(WIN_LEN / GRP_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   min_4s_en,
    input  logic [LANES*CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0]       min_shift,
    output logic                   min_valid,
    output logic [IDX_W-1:0]       grp_idx,
    output logic                   trunc,
    output logic                   busy
);

    import cbfp0_pkg::state_t;

    localparam int                  N_GROUPS = WIN_LEN / GRP_LEN;
    localparam int                  CYC_BITS = $clog2(GRP_LEN) + 1;
    localparam logic [CNT_W-1:0]    SAT      = CNT_W'(SHIFT_MAX);
    localparam logic [CYC_BITS-1:0] CYC_LAST = CYC_BITS'(GRP_LEN - 1);
    localparam logic [IDX_W-1:0]    GRP_LAST = IDX_W'(N_GROUPS - 1);

    if (WIN_LEN % GRP_LEN != 0) begin : g_bad_len
        $error("WIN_LEN must be a multiple of GRP_LEN");
    end

    logic                p1_en;
    logic [CNT_W-1:0]    lane_min;
    state_t              state;
    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    m;
    logic [CYC_BITS-1:0] cyc_cnt;
    logic [IDX_W-1:0]    grp_cnt;

    cbfp0_lane_min #(
        .LANES     (LANES),
        .CNT_W     (CNT_W),
        .SHIFT_MAX (SHIFT_MAX)
    ) u_lane_min (
        .clk      (clk),
        .rst      (rst),
        .en_in    (min_4s_en),
        .cnt_in   (cnt_in),
        .en_out   (p1_en),
        .lane_min (lane_min)
    );

    assign m = (lane_min < acc) ? lane_min : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= cbfp0_pkg::IDLE;
            acc       <= SAT;
            cyc_cnt   <= '0;
            grp_cnt   <= '0;
            min_shift <= '0;
            min_valid <= 1'b0;
            grp_idx   <= '0;
            trunc     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Pulses default low so each event lasts exactly one cycle.
            min_valid <= 1'b0;
            trunc     <= 1'b0;
            case (state)
                cbfp0_pkg::IDLE: begin
                    if (p1_en) begin
                        state   <= cbfp0_pkg::ACC;
                        busy    <= 1'b1;
                        acc     <= lane_min;
                        cyc_cnt <= CYC_BITS'(1);
                        grp_cnt <= '0;
                    end
                end
                cbfp0_pkg::ACC: begin
                    if (p1_en) begin
                        if (cyc_cnt == CYC_LAST) begin
                            min_valid <= 1'b1;
                            min_shift <= m;
                            grp_idx   <= grp_cnt;
                            acc       <= SAT;
                            cyc_cnt   <= '0;
                            grp_cnt   <= grp_cnt + IDX_W'(1);
                            if (grp_cnt == GRP_LAST) begin
                                state <= cbfp0_pkg::IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            acc     <= m;
                            cyc_cnt <= cyc_cnt + CYC_BITS'(1);
                        end
                    end else begin
                        // Early drop: flush a partial group only if it holds samples.
                        trunc <= 1'b1;
                        state <= cbfp0_pkg::IDLE;
                        busy  <= 1'b0;
                        if (cyc_cnt != '0) begin
                            min_valid <= 1'b1;
                            min_shift <= acc;
                            grp_idx   <= grp_cnt;
                        end
                    end
                end
                default: begin
                    state <= cbfp0_pkg::IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbfp0_min_shift_acc.sv
// Scoreboard bench for cbfp0_min_shift_acc: expected pulses are queued when
// a window is driven and compared in the cycle the DUT should produce them.
module tb_cbfp0_min_shift_acc;

    localparam int LANES = 4;
    localparam int CNT_W = 5;
    localparam int WIN   = 32;
    localparam int GRP   = 8;
    localparam int SMAX  = 20;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [LANES*CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0]       min_shift;
    logic                   min_valid;
    logic [1:0]             grp_idx;
    logic                   trunc;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        bit v;
        bit t;
        int ms;
        int gi;
    } exp_t;

    exp_t sb[$];

    cbfp0_min_shift_acc dut (
        .clk       (clk),
        .rst       (rst),
        .min_4s_en (en),
        .cnt_in    (cnt_in),
        .min_shift (min_shift),
        .min_valid (min_valid),
        .grp_idx   (grp_idx),
        .trunc     (trunc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare DUT pulses against the scoreboard on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_event_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("min_valid", int'(min_valid), int'(e.v));
            check("trunc", int'(trunc), int'(e.t));
            if (e.v) begin
                check("min_shift", int'(min_shift), e.ms);
                check("grp_idx", int'(grp_idx), e.gi);
            end
        end else if (min_valid || trunc) begin
            check("spurious_pulse", int'({min_valid, trunc}), 0);
        end
    end

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            en     = 1'b0;
            cnt_in = (LANES*CNT_W)'($urandom);
        end
    endtask

    // mode 0: 15s with two dips; 1: all 31; 2: 12s with one dip; else random.
    task automatic drive_window(input int n, input int mode, input bit push);
        int t0;
        int acc;
        int cnt;
        int grp;
        int lm;
        int v;
        logic [LANES*CNT_W-1:0] word;
        t0   = 0;
        acc  = SMAX;
        cnt  = 0;
        grp  = 0;
        word = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) t0 = cyc;
            lm = SMAX;
            for (int l = 0; l < LANES; l++) begin
                case (mode)
                    0:       v = (c == 3 && l == 2) ? 6 : ((c == 20 && l == 0) ? 2 : 15);
                    1:       v = 31;
                    2:       v = (c == 9 && l == 1) ? 7 : 12;
                    default: v = int'($urandom_range(0, 31));
                endcase
                word[l*CNT_W +: CNT_W] = CNT_W'(v);
                if (v < lm) lm = v;
            end
            en     = 1'b1;
            cnt_in = word;
            if (lm < acc) acc = lm;
            cnt++;
            if (cnt == GRP) begin
                if (push) sb.push_back('{t0 + c + 2, 1'b1, 1'b0, acc, grp});
                acc = SMAX;
                cnt = 0;
                grp++;
            end
        end
        if (push && n < WIN) begin
            sb.push_back('{t0 + n + 2, (cnt > 0), 1'b1, acc, grp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        cnt_in = '0;

        // Reset held three cycles while the enable toggles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            en     = ~en;
            cnt_in = (LANES*CNT_W)'($urandom);
            @(negedge clk);
            check("rst_min_shift", int'(min_shift), 0);
            check("rst_min_valid", int'(min_valid), 0);
            check("rst_grp_idx", int'(grp_idx), 0);
            check("rst_trunc", int'(trunc), 0);
            check("rst_busy", int'(busy), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        idle(2);

        // Full window with known minima, then busy drop at t0+33.
        drive_window(WIN, 0, 1'b1);
        idle(1);
        @(negedge clk);
        check("busy_at_t0p32", int'(busy), 1);
        idle(1);
        @(negedge clk);
        check("busy_at_t0p33", int'(busy), 0);
        idle(2);

        // Saturation: every lane above SHIFT_MAX.
        drive_window(WIN, 1, 1'b1);
        idle(3);

        // Truncation mid-group and on a group boundary.
        drive_window(11, 2, 1'b1);
        idle(3);
        drive_window(16, 3, 1'b1);
        idle(3);

        // Back-to-back windows with zero and one idle cycle between them.
        drive_window(WIN, 3, 1'b1);
        drive_window(WIN, 3, 1'b1);
        idle(1);
        drive_window(WIN, 3, 1'b1);
        idle(3);

        // Reset asserted at t0+5 abandons the window silently.
        drive_window(5, 3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_mid_reset", int'(busy), 0);
        idle(3);
        drive_window(WIN, 0, 1'b1);
        idle(2);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
